// File: rtl/mem_port_pipelined.sv
// Single-ported word RAM data port with byte/half/word access, valid/ready
// request and response channels, programmable latency and fault reporting.
module mem_port_pipelined #(
    parameter int unsigned WORDS     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          IS_STACK  = 1'b0,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [32*WORDS-1:0]   init_data_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_vptr_i,
    input  logic [31:0]           req_sw_data_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [31:0]           resp_lw_data_o,
    output logic [1:0]            resp_fault_o,
    input  logic                  en_trace_i
);

    localparam int unsigned AW           = $clog2(WORDS);
    localparam logic [31:0] REGION_BYTES = 32'(4 * WORDS);
    localparam logic [31:0] REGION_LOW   = IS_STACK ? (BASE_ADDR - REGION_BYTES) : BASE_ADDR;
    localparam int unsigned CW           = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD   = CW'(LATENCY - 1);

    localparam logic [1:0] F_OK    = 2'd0;
    localparam logic [1:0] F_ALIGN = 2'd1;
    localparam logic [1:0] F_RANGE = 2'd2;
    localparam logic [1:0] F_SIZE  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [1:0]     fault_q, fault_d;
    logic [31:0]    mem_q [WORDS];

    logic [31:0]    off;
    logic           in_range;
    logic [AW-1:0]  slot;
    logic [1:0]     lane;
    logic [1:0]     fault_c;
    logic           accept;
    logic           we_fire;
    logic [31:0]    rd_word;
    logic [31:0]    shifted;
    logic [31:0]    load_val;
    logic [3:0]     be;
    logic [31:0]    wdata;
    logic           trace_evt_unused;

    // Underflow below the region wraps to a large offset and so reads as out of range.
    assign off      = req_vptr_i - REGION_LOW;
    assign in_range = off < REGION_BYTES;
    assign slot     = off[AW+1:2];
    assign lane     = req_vptr_i[1:0];

    always_comb begin
        fault_c = F_OK;
        if (req_size_i == 2'd3)
            fault_c = F_SIZE;
        else if ((req_size_i == 2'd1 && lane[0]) || (req_size_i == 2'd2 && lane != 2'd0))
            fault_c = F_ALIGN;
        else if (!in_range)
            fault_c = F_RANGE;
    end

    assign accept  = req_valid_i && req_ready_o;
    assign we_fire = accept && req_we_i && (fault_c == F_OK);

    assign rd_word = mem_q[slot];
    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        load_val = rd_word;
        unique case (req_size_i)
            2'd0:    load_val = req_unsigned_i ? {24'h0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = req_unsigned_i ? {16'h0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        be    = 4'b1111;
        wdata = req_sw_data_i;
        unique case (req_size_i)
            2'd0: begin
                be    = 4'b0001 << lane;
                wdata = {4{req_sw_data_i[7:0]}};
            end
            2'd1: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{req_sw_data_i[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = req_sw_data_i;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned k = 0; k < WORDS; k++)
                mem_q[k] <= init_data_i[32*k +: 32];
        end else if (we_fire) begin
            for (int unsigned b = 0; b < 4; b++)
                if (be[b])
                    mem_q[slot][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        unique case (state_q)
            S_IDLE: ;
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = S_RESP;
            end
            S_RESP: if (resp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A pop and a fresh accept can share one edge; the accept wins.
        if (accept) begin
            state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
            cnt_d   = CNT_LOAD;
            rdata_d = (fault_c == F_OK && !req_we_i) ? load_val : '0;
            fault_d = fault_c;
        end
    end

    always_comb begin
        req_ready_o    = !reset_i && (state_q == S_IDLE || (state_q == S_RESP && resp_ready_i));
        resp_valid_o   = (state_q == S_RESP);
        resp_lw_data_o = rdata_q;
        resp_fault_o   = fault_q;
    end

    // Trace events (accepted stores and faults) are left for simulation probes only.
    assign trace_evt_unused = en_trace_i && accept && (req_we_i || fault_c != F_OK);

endmodule

// File: tb/tb_mem_port_pipelined.sv
// Directed bench: a flat-region port (16 words @0x1000, latency 2) and a
// stack-region port (16 words below 0x8000, latency 1).
module tb_mem_port_pipelined;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]        req_valid, req_ready, req_we, req_uns, resp_valid, resp_ready, en_trace;
    logic [1:0][1:0]   req_size, resp_fault;
    logic [1:0][31:0]  req_vptr, req_wd, resp_data;
    logic [16*32-1:0]  init_a, init_s;

    int errors = 0;
    int checks = 0;
    int lat_of [2] = '{2, 1};

    mem_port_pipelined #(.WORDS(16), .BASE_ADDR(32'h0000_1000), .IS_STACK(1'b0), .LATENCY(2)) dut (
        .clk_i(clk), .reset_i(reset), .init_data_i(init_a),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_size_i(req_size[0]), .req_unsigned_i(req_uns[0]), .req_vptr_i(req_vptr[0]),
        .req_sw_data_i(req_wd[0]), .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .resp_lw_data_o(resp_data[0]), .resp_fault_o(resp_fault[0]), .en_trace_i(en_trace[0]));

    mem_port_pipelined #(.WORDS(16), .BASE_ADDR(32'h0000_8000), .IS_STACK(1'b1), .LATENCY(1)) dut_s (
        .clk_i(clk), .reset_i(reset), .init_data_i(init_s),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_size_i(req_size[1]), .req_unsigned_i(req_uns[1]), .req_vptr_i(req_vptr[1]),
        .req_sw_data_i(req_wd[1]), .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .resp_lw_data_o(resp_data[1]), .resp_fault_o(resp_fault[1]), .en_trace_i(en_trace[1]));

    typedef struct {
        int unsigned d;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic [1:0]  exp_f;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_access(input int unsigned d, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_d, input logic [1:0] exp_f, input string nm);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size; req_uns[d] = uns;
        req_vptr[d] = addr; req_wd[d] = wd; resp_ready[d] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[d] && n < 20) begin @(negedge clk); #1; n++; end
        if (!req_ready[d]) begin
            chk({nm, " accept-timeout"}, 32'(req_ready[d]), 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        n = 1;
        while (!resp_valid[d] && n < 10) begin @(negedge clk); n++; end
        chk({nm, " valid"}, 32'(resp_valid[d]), 32'd1);
        chk({nm, " latency"}, 32'(n), 32'(lat_of[d]));
        chk({nm, " data"}, resp_data[d], exp_d);
        chk({nm, " fault"}, 32'(resp_fault[d]), 32'(exp_f));
    endtask

    task automatic add(input int unsigned d, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] ed,
                       input logic [1:0] ef);
        vec_t v;
        v.d = d; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wd = wd;
        v.exp_d = ed; v.exp_f = ef;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 16; k++) begin
            init_a[32*k +: 32] = 32'hA000_0000 + 32'(k);
            init_s[32*k +: 32] = 32'hB000_0000 + 32'(k);
        end
        // flat region, latency 2
        add(0, 0, 2, 0, 32'h1008, 0, 32'hA000_0002, 0);
        add(0, 1, 0, 0, 32'h1005, 32'h0000_0080, 0, 0);
        add(0, 0, 2, 0, 32'h1004, 0, 32'hA000_8001, 0);
        add(0, 0, 0, 0, 32'h1005, 0, 32'hFFFF_FF80, 0);
        add(0, 0, 0, 1, 32'h1005, 0, 32'h0000_0080, 0);
        add(0, 1, 2, 0, 32'h1002, 32'hFFFF_FFFF, 0, 1);
        add(0, 0, 2, 0, 32'h1000, 0, 32'hA000_0000, 0);
        add(0, 0, 2, 0, 32'h1040, 0, 0, 2);
        add(0, 0, 2, 0, 32'h0FFC, 0, 0, 2);
        add(0, 0, 3, 0, 32'h1002, 0, 0, 3);
        add(0, 0, 2, 0, 32'h1042, 0, 0, 1);
        add(0, 0, 1, 0, 32'h1006, 0, 32'hFFFF_A000, 0);
        add(0, 0, 1, 0, 32'h1005, 0, 0, 1);
        add(0, 1, 1, 0, 32'h100A, 32'h1234_BEEF, 0, 0);
        add(0, 0, 2, 0, 32'h1008, 0, 32'hBEEF_0002, 0);
        add(0, 0, 1, 1, 32'h100A, 0, 32'h0000_BEEF, 0);
        add(0, 1, 2, 0, 32'h103C, 32'hDEAD_BEEF, 0, 0);
        add(0, 0, 0, 0, 32'h103F, 0, 32'hFFFF_FFDE, 0);
        add(0, 1, 3, 0, 32'h1000, 32'h1234_5678, 0, 3);
        add(0, 0, 2, 0, 32'h1000, 0, 32'hA000_0000, 0);
        add(0, 1, 2, 0, 32'h1040, 32'h0, 0, 2);
        // stack region [0x7FC0, 0x8000), latency 1
        add(1, 0, 2, 0, 32'h7FFC, 0, 32'hB000_000F, 0);
        add(1, 0, 2, 0, 32'h7FC0, 0, 32'hB000_0000, 0);
        add(1, 1, 2, 0, 32'h7FFC, 32'h5555_AAAA, 0, 0);
        add(1, 0, 2, 0, 32'h7FFC, 0, 32'h5555_AAAA, 0);
        add(1, 1, 2, 0, 32'h7FC0, 32'h0102_0304, 0, 0);
        add(1, 0, 2, 0, 32'h7FC0, 0, 32'h0102_0304, 0);
        add(1, 0, 2, 0, 32'h7FC4, 0, 32'hB000_0001, 0);
        add(1, 0, 2, 0, 32'h7FBC, 0, 0, 2);
        add(1, 0, 2, 0, 32'h8000, 0, 0, 2);
        add(1, 0, 0, 1, 32'h7FC1, 0, 32'h0000_0003, 0);

        reset = 1'b1;
        req_valid = '0; req_we = '0; req_uns = '0; resp_ready = '1; en_trace = '1;
        req_size = '0; req_vptr = '0; req_wd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("rst%0d ready-in-reset", d), 32'(req_ready[d]), 32'd0);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d ready", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("rst%0d valid", d), 32'(resp_valid[d]), 32'd0);
            chk($sformatf("rst%0d data", d), resp_data[d], 32'd0);
            chk($sformatf("rst%0d fault", d), 32'(resp_fault[d]), 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++)
            do_access(vecs[i].d, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                      vecs[i].wd, vecs[i].exp_d, vecs[i].exp_f, $sformatf("vec%0d", i));

        // backpressure: hold the response, then pop and accept on one edge
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'd2; req_uns[0] = 1'b0;
        req_vptr[0] = 32'h1000; resp_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (!resp_valid[0] && n < 10) begin @(negedge clk); n++; end
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d valid", c), 32'(resp_valid[0]), 32'd1);
            chk($sformatf("bp%0d data", c), resp_data[0], 32'hA000_0000);
            chk($sformatf("bp%0d ready", c), 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        req_valid[0] = 1'b1; req_vptr[0] = 32'h1004; resp_ready[0] = 1'b1;
        #1;
        chk("bp pop ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("bp wait valid", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        chk("bp next valid", 32'(resp_valid[0]), 32'd1);
        chk("bp next data", resp_data[0], 32'hA000_8001);

        // reset while a load is in WAIT; a store offered during reset must be ignored
        do_access(0, 1, 2, 0, 32'h1000, 32'h1111_1111, 0, 0, "pre-rst store");
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'd2; req_vptr[0] = 32'h1000;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        req_we[0] = 1'b1; req_wd[0] = 32'h2222_2222;
        #1;
        chk("midrst ready-in-reset", 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; req_valid[0] = 1'b0; req_we[0] = 1'b0;
        #1;
        chk("midrst valid", 32'(resp_valid[0]), 32'd0);
        chk("midrst ready", 32'(req_ready[0]), 32'd1);
        chk("midrst data", resp_data[0], 32'd0);
        @(negedge clk);
        chk("midrst valid later", 32'(resp_valid[0]), 32'd0);
        do_access(0, 0, 2, 0, 32'h1000, 0, 32'hA000_0000, 0, "post-rst load");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_pipelined.md
Name: mem_port_pipelined

Overview:
- Next-generation data-memory port for the uarch simulator's load/store path.
- Single-ported word-organised RAM with parametrised depth, base address and stack mode.
- Supports byte, half and word accesses with sign/zero extension.
- Valid/ready request and response handshake, programmable access latency, fault reporting for misaligned, out-of-range and illegal-size accesses.

Parameters:
- WORDS, 32: number of 32-bit slots; must be a power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: if IS_STACK=0, lowest byte address of the region; if IS_STACK=1, exclusive top address.
- IS_STACK, 0: 0 maps region [BASE_ADDR, BASE_ADDR+4*WORDS); 1 maps region [BASE_ADDR-4*WORDS, BASE_ADDR).
- LATENCY, 1: accept-to-response delay in cycles; must be at least 1.

Ports:
- _clk  in  1  clock
- _reset  in  1  synchronous, active-high reset; one clock, sampled on rising edge
- _init_data  in  32*WORDS  preload image; word k occupies bits [32k+31:32k]
- _req_valid  in  1  request present
- req_ready_  out  1  request accepted when _req_valid && req_ready_
- _req_we  in  1  1 = store, 0 = load
- _req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- _req_unsigned  in  1  loads only: zero-extend instead of sign-extend
- _req_vptr  in  32  byte address
- _req_sw_data  in  32  store data, right-aligned
- resp_valid_  out  1  response present
- _resp_ready  in  1  response consumed when resp_valid_ && _resp_ready
- resp_lw_data_  out  32  load result, extended; 0 for stores and faults
- resp_fault_  out  2  0 = ok, 1 = misaligned, 2 = out of range, 3 = illegal size
- _en_trace  in  1  enable trace log of accepted stores and faults

Behaviour:
- Address translation:
  - off = _req_vptr - region_low.
  - In range iff off < 4*WORDS (unsigned; underflow counts as out of range).
  - slot = off[log2(WORDS)+1:2]; lane = _req_vptr[1:0].
- Fault priority: size==3, then misaligned (half with lane[0]=1, or word with lane!=0), then out of range.
- A faulting access does not touch memory. Response carries the fault code and data 0.
- States: IDLE, WAIT, RESP.
- req_ready_ = !_reset && (IDLE || (RESP && _resp_ready)). Combinational; permits a new accept in the same cycle as a response pop.
- On accept edge:
  - Store: write byte lanes in the same edge. Byte writes _req_sw_data[7:0] to lane; half writes [15:0] to lanes {vptr[1],0} and +1; word writes all four lanes. Other lanes are preserved.
  - Load: read and extend the addressed slot/lane; capture into the response register.
  - Fault code is captured. Counter is loaded with LATENCY-1.
- Transitions:
  - Accept with LATENCY==1 goes to RESP.
  - Accept with LATENCY>1 goes to WAIT.
  - WAIT decrements the counter each cycle and goes to RESP when the counter reaches 1.
  - RESP with pop and no new accept goes to IDLE.
  - RESP with pop and a new accept follows the accept rules above.
- Latency: resp_valid_ rises exactly LATENCY cycles after the accept edge. Throughput is one access per LATENCY cycles if _resp_ready is held high.
- Response stability: resp_valid_, resp_lw_data_ and resp_fault_ hold constant while resp_valid_ && !_resp_ready.
- Ordering: one outstanding request only. A load issued after a store observes that store.
- Reset, including mid-WAIT or mid-RESP:
  - Next state is IDLE. resp_valid_=0, resp_lw_data_=0, resp_fault_=0, counter=0.
  - memory[k] <= _init_data word k for all k; any in-flight request is dropped.
  - No request is accepted in a reset cycle.
- Trace: when _en_trace=1, log one line per accepted store (address, data, size) and per fault (address, code). No output effect.

Test Plan:
- Setup for tests 1–4 and 6: WORDS=16, BASE_ADDR=0x1000, IS_STACK=0, LATENCY=2, init word k = 0xA000_0000+k.
- Word load: reset, then load word 0x1008 -> resp_valid_ exactly 2 cycles after accept; data 0xA000_0002, fault 0.
- Byte store and extension:
  - Store byte 0x1005 with data 0x0000_0080, then load word 0x1004 -> 0xA000_8001.
  - Load byte 0x1005 signed -> 0xFFFF_FF80; unsigned -> 0x0000_0080.
- Faults:
  - Store word 0x1002 -> fault 1, memory unchanged.
  - Load word 0x1040 -> fault 2.
  - Load word 0x0FFC -> fault 2.
  - Size 3 at 0x1002 -> fault 3 (priority over misalignment).
- Backpressure:
  - Hold _resp_ready=0 for 3 cycles -> resp_valid_/data stable, req_ready_=0.
  - Raise _resp_ready with _req_valid=1 -> pop and accept on the same edge.
- Stack mode (IS_STACK=1, BASE_ADDR=0x8000, WORDS=16, LATENCY=1):
  - Store word 0x7FFC lands in slot 15; 0x7FC0 lands in slot 0.
  - 0x7FBC and 0x8000 -> fault 2.
  - Load after store returns the stored value 1 cycle after accept.
- Reset mid-WAIT: accept a load, assert _reset the next cycle -> resp_valid_=0, req_ready_=1 after reset; a store made before reset is reverted to the init image.
